// File: rtl/riscv_bus_pkg.sv
// Shared bus types for the TinyRISC-V core/memory interconnect.
package riscv_bus_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP
    } bus_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_LSU
    } bus_owner_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter (fetch / load-store) in front of the single-port memory.
// One transaction outstanding; response routed to the owner, with an RSP timeout.
module mem_bus_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int AW           = BUS_AW,
    parameter int DW           = BUS_DW,
    parameter int STARVE_LIMIT = 4,
    parameter int RSP_TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            m0_req_i,
    input  logic [AW-1:0]   m0_addr_i,
    output logic            m0_gnt_o,
    output logic            m0_rvalid_o,
    output logic [DW-1:0]   m0_rdata_o,
    output logic            m0_err_o,

    input  logic            m1_req_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_be_i,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic [DW-1:0]   m1_wdata_i,
    output logic            m1_gnt_o,
    output logic            m1_rvalid_o,
    output logic [DW-1:0]   m1_rdata_o,
    output logic            m1_err_o,

    output logic            s_req_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_be_o,
    output logic [AW-1:0]   s_addr_o,
    output logic [DW-1:0]   s_wdata_o,
    input  logic            s_gnt_i,
    input  logic            s_rvalid_i,
    input  logic [DW-1:0]   s_rdata_i
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(RSP_TIMEOUT + 1);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TLIM = TW'(RSP_TIMEOUT - 1);

    bus_state_e      state, state_nxt;
    bus_owner_e      owner, owner_nxt;
    logic [SW-1:0]   starve_cnt, starve_nxt;
    logic [TW-1:0]   tcnt, tcnt_nxt;
    logic            s_req_nxt, s_we_nxt;
    logic [DW/8-1:0] s_be_nxt;
    logic [AW-1:0]   s_addr_nxt;
    logic [DW-1:0]   s_wdata_nxt;
    logic            m0_gnt_nxt, m1_gnt_nxt;
    logic            pick_m0, timeout, rsp_fire;
    logic [DW-1:0]   rsp_data;

    assign pick_m0 = m0_req_i && (!m1_req_i || starve_cnt == SLIM);
    assign timeout = (state == RSP) && (tcnt == TLIM) && !s_rvalid_i;

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        starve_nxt  = starve_cnt;
        tcnt_nxt    = tcnt;
        s_req_nxt   = s_req_o;
        s_we_nxt    = s_we_o;
        s_be_nxt    = s_be_o;
        s_addr_nxt  = s_addr_o;
        s_wdata_nxt = s_wdata_o;
        m0_gnt_nxt  = 1'b0;
        m1_gnt_nxt  = 1'b0;

        if (!m0_req_i)
            starve_nxt = '0;

        case (state)
            IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    state_nxt = REQ;
                    s_req_nxt = 1'b1;
                    if (pick_m0) begin
                        owner_nxt   = OWN_IF;
                        s_we_nxt    = 1'b0;
                        s_be_nxt    = '1;
                        s_addr_nxt  = m0_addr_i;
                        s_wdata_nxt = '0;
                        starve_nxt  = '0;
                    end else begin
                        owner_nxt   = OWN_LSU;
                        s_we_nxt    = m1_we_i;
                        s_be_nxt    = m1_be_i;
                        s_addr_nxt  = m1_addr_i;
                        s_wdata_nxt = m1_wdata_i;
                        // m0 is being passed over: count it toward its forced turn
                        if (m0_req_i && starve_cnt != SLIM)
                            starve_nxt = starve_cnt + 1'b1;
                    end
                end
            end
            REQ: begin
                if (s_gnt_i) begin
                    state_nxt  = RSP;
                    s_req_nxt  = 1'b0;
                    tcnt_nxt   = '0;
                    m0_gnt_nxt = (owner == OWN_IF);
                    m1_gnt_nxt = (owner == OWN_LSU);
                end
            end
            RSP: begin
                if (s_rvalid_i || timeout)
                    state_nxt = IDLE;
                else
                    tcnt_nxt = tcnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            starve_cnt <= '0;
            tcnt       <= '0;
            s_req_o    <= 1'b0;
            s_we_o     <= 1'b0;
            s_be_o     <= '0;
            s_addr_o   <= '0;
            s_wdata_o  <= '0;
            m0_gnt_o   <= 1'b0;
            m1_gnt_o   <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
            tcnt       <= tcnt_nxt;
            s_req_o    <= s_req_nxt;
            s_we_o     <= s_we_nxt;
            s_be_o     <= s_be_nxt;
            s_addr_o   <= s_addr_nxt;
            s_wdata_o  <= s_wdata_nxt;
            m0_gnt_o   <= m0_gnt_nxt;
            m1_gnt_o   <= m1_gnt_nxt;
        end
    end

    // Response path is combinational; a forced timeout returns zero data
    assign rsp_fire = (state == RSP) && (s_rvalid_i || timeout);
    assign rsp_data = (state == RSP && !timeout) ? s_rdata_i : '0;

    assign m0_rvalid_o = rsp_fire && (owner == OWN_IF);
    assign m1_rvalid_o = rsp_fire && (owner == OWN_LSU);
    assign m0_rdata_o  = (owner == OWN_IF)  ? rsp_data : '0;
    assign m1_rdata_o  = (owner == OWN_LSU) ? rsp_data : '0;
    assign m0_err_o    = timeout && (owner == OWN_IF);
    assign m1_err_o    = timeout && (owner == OWN_LSU);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized + directed bench for mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req_i = 1'b0, m0_gnt_o, m0_rvalid_o, m0_err_o;
    logic [AW-1:0] m0_addr_i = '0;
    logic [DW-1:0] m0_rdata_o;
    logic          m1_req_i = 1'b0, m1_we_i = 1'b0, m1_gnt_o, m1_rvalid_o, m1_err_o;
    logic [3:0]    m1_be_i = '0;
    logic [AW-1:0] m1_addr_i = '0;
    logic [DW-1:0] m1_wdata_i = '0, m1_rdata_o;
    logic          s_req_o, s_we_o, s_gnt_i = 1'b0, s_rvalid_i = 1'b0;
    logic [3:0]    s_be_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_wdata_o, s_rdata_i = '0;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL), .RSP_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;

    // master intent: number of transactions still to issue
    int m0_left = 0, m1_left = 0;
    bit rnd_mode = 0;
    logic [31:0] m0_a = '0, m1_a = '0, m1_wd = '0;
    logic [3:0]  m1_be = '0;
    logic        m1_we = 1'b0;

    // slave behaviour
    int gnt_delay = 0, rsp_delay = 0, stray_cyc = -1;
    bit use_fixed = 0;
    logic [31:0] fixed_rdata = '0;
    bit sl_pend = 0, sl_never = 0;
    int sl_delay = 0, req_cycles = 0;

    // transaction-level model
    bit mv = 0, macc = 0, mown = 0, mwe = 0;
    logic [31:0] ma = '0, mwd = '0;
    logic [3:0]  mbe = '0;
    int mrc = 0, mstarve = 0;

    // observation log
    int gnt_cnt[2], rv_cnt[2];
    logic [31:0] last_rd[2];
    bit last_err[2];
    int sreq_cycles, sreq_rise_cyc, req_rise_cyc, last_gnt_cyc, last_rv_cyc;
    bit prev_sreq = 0, prev_m0req = 0;
    logic [31:0] cap_addr, cap_wd;
    logic [3:0]  cap_be;
    logic        cap_we;
    int gnt_order[$];
    int exp_ord[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clr_log();
        gnt_cnt[0] = 0; gnt_cnt[1] = 0; rv_cnt[0] = 0; rv_cnt[1] = 0;
        last_rd[0] = '0; last_rd[1] = '0; last_err[0] = 0; last_err[1] = 0;
        sreq_cycles = 0; sreq_rise_cyc = -1; req_rise_cyc = -1;
        last_gnt_cyc = -1; last_rv_cyc = -1;
        gnt_order.delete();
    endtask

    task automatic mdl_reset();
        mv = 0; macc = 0; mrc = 0; mstarve = 0;
        sl_pend = 0; sl_never = 0; sl_delay = 0; req_cycles = 0;
        prev_sreq = 0; prev_m0req = 0;
    endtask

    task automatic step();
        bit in_rsp, fire_rv, fire_to, sl_issue, sreq_s, g0, g1, acc_now, pick0;
        int r;
        @(negedge clk);
        m0_req_i = (m0_left > 0); m0_addr_i = m0_a;
        m1_req_i = (m1_left > 0); m1_addr_i = m1_a; m1_we_i = m1_we;
        m1_be_i = m1_be; m1_wdata_i = m1_wd;
        if (m0_req_i && !prev_m0req) req_rise_cyc = cyc;
        prev_m0req = m0_req_i;
        in_rsp = mv && macc;
        if (gnt_delay < 0) s_gnt_i = s_req_o && ($urandom_range(0, 2) == 0);
        else               s_gnt_i = s_req_o && (req_cycles >= gnt_delay);
        sl_issue = sl_pend && !sl_never && sl_delay == 0;
        s_rdata_i = use_fixed ? fixed_rdata : $urandom;
        s_rvalid_i = sl_issue ||
                     (!in_rsp && (cyc == stray_cyc || (rnd_mode && $urandom_range(0, 7) == 0)));
        #1;
        fire_rv = in_rsp && s_rvalid_i;
        fire_to = in_rsp && !s_rvalid_i && mrc == TO - 1;
        chk("s_req", s_req_o, mv && !macc);
        if (mv && !macc) begin
            chk("s_addr", s_addr_o, ma);
            chk("s_we", s_we_o, mwe);
            chk("s_be", s_be_o, mbe);
            chk("s_wdata", s_wdata_o, mwd);
        end
        chk("m0_gnt", m0_gnt_o, in_rsp && mrc == 0 && mown == 0);
        chk("m1_gnt", m1_gnt_o, in_rsp && mrc == 0 && mown == 1);
        chk("m0_rvalid", m0_rvalid_o, (fire_rv || fire_to) && mown == 0);
        chk("m1_rvalid", m1_rvalid_o, (fire_rv || fire_to) && mown == 1);
        chk("m0_err", m0_err_o, fire_to && mown == 0);
        chk("m1_err", m1_err_o, fire_to && mown == 1);
        chk("m0_rdata", m0_rdata_o, (in_rsp && mown == 0 && !fire_to) ? s_rdata_i : 32'h0);
        chk("m1_rdata", m1_rdata_o, (in_rsp && mown == 1 && !fire_to) ? s_rdata_i : 32'h0);

        sreq_s = s_req_o; g0 = m0_gnt_o; g1 = m1_gnt_o;
        if (s_req_o) sreq_cycles++;
        if (s_req_o && !prev_sreq) begin
            sreq_rise_cyc = cyc; cap_addr = s_addr_o; cap_we = s_we_o;
            cap_be = s_be_o; cap_wd = s_wdata_o;
        end
        prev_sreq = s_req_o;
        if (g0) begin gnt_cnt[0]++; gnt_order.push_back(0); last_gnt_cyc = cyc; end
        if (g1) begin gnt_cnt[1]++; gnt_order.push_back(1); last_gnt_cyc = cyc; end
        if (m0_rvalid_o) begin rv_cnt[0]++; last_rd[0] = m0_rdata_o; last_err[0] = m0_err_o; last_rv_cyc = cyc; end
        if (m1_rvalid_o) begin rv_cnt[1]++; last_rd[1] = m1_rdata_o; last_err[1] = m1_err_o; last_rv_cyc = cyc; end

        @(posedge clk);
        cyc++;
        if (rst_n) begin
            if (!mv) begin
                if (m0_req_i || m1_req_i) begin
                    pick0 = m0_req_i && (!m1_req_i || mstarve == SL);
                    mv = 1; macc = 0;
                    if (pick0) begin
                        mown = 0; ma = m0_addr_i; mwe = 0; mbe = 4'hf; mwd = '0; mstarve = 0;
                    end else begin
                        mown = 1; ma = m1_addr_i; mwe = m1_we_i; mbe = m1_be_i; mwd = m1_wdata_i;
                        if (m0_req_i && mstarve < SL) mstarve++;
                    end
                end
            end else if (!macc) begin
                if (s_gnt_i) begin macc = 1; mrc = 0; end
            end else if (fire_rv || fire_to) mv = 0;
            else mrc++;
            if (!m0_req_i) mstarve = 0;

            acc_now = sreq_s && s_gnt_i;
            if (sl_issue) sl_pend = 0;
            else if (sl_pend && !sl_never && sl_delay > 0) sl_delay--;
            if (fire_to) sl_pend = 0;
            if (acc_now) begin
                sl_pend = 1;
                if (rsp_delay < 0) begin
                    r = $urandom_range(0, 19);
                    sl_never = (r == 0); sl_delay = r % 4;
                end else begin
                    sl_never = (rsp_delay >= 99); sl_delay = rsp_delay;
                end
            end
            req_cycles = (sreq_s && !acc_now) ? req_cycles + 1 : 0;

            if (g0) m0_left--;
            if (g1) m1_left--;
            if (rnd_mode && m0_left <= 0 && $urandom_range(0, 2) == 0) m0_left = 1;
            if (rnd_mode && m1_left <= 0 && $urandom_range(0, 2) == 0) m1_left = 1;
            if (g0 || (rnd_mode && !m0_req_i)) m0_a = $urandom & 32'hffff_fffc;
            if (g1 || (rnd_mode && !m1_req_i)) begin
                m1_a = $urandom; m1_wd = $urandom;
                m1_be = 4'($urandom); m1_we = 1'($urandom);
            end
        end
    endtask

    initial begin
        clr_log();
        mdl_reset();

        // reset state
        repeat (2) step();
        chk("rst_s_req", s_req_o, 1'b0);
        chk("rst_s_addr", s_addr_o, 32'h0);
        chk("rst_gnt", {m0_gnt_o, m1_gnt_o}, 2'b00);
        #2 rst_n = 1'b1;

        // single fetch, immediate grant, response next cycle
        clr_log();
        m0_a = 32'h10; m0_left = 1; gnt_delay = 0; rsp_delay = 0;
        use_fixed = 1; fixed_rdata = 32'hDEAD_BEEF;
        repeat (6) step();
        chk("t1_sreq_lat", sreq_rise_cyc, req_rise_cyc + 1);
        chk("t1_addr", cap_addr, 32'h10);
        chk("t1_we", cap_we, 1'b0);
        chk("t1_gnt_cnt", gnt_cnt[0], 1);
        chk("t1_rv_cnt", rv_cnt[0], 1);
        chk("t1_rdata", last_rd[0], 32'hDEAD_BEEF);
        chk("t1_err", last_err[0], 1'b0);
        chk("t1_m1_rv", rv_cnt[1], 0);

        // store with delayed grant
        clr_log();
        m1_a = 32'h100; m1_wd = 32'h1234_5678; m1_be = 4'b0011; m1_we = 1'b1;
        m1_left = 1; gnt_delay = 3; rsp_delay = 1;
        repeat (10) step();
        chk("t2_req_cycles", sreq_cycles, 4);
        chk("t2_addr", cap_addr, 32'h100);
        chk("t2_wdata", cap_wd, 32'h1234_5678);
        chk("t2_be", cap_be, 4'b0011);
        chk("t2_we", cap_we, 1'b1);
        chk("t2_gnt_cnt", gnt_cnt[1], 1);
        chk("t2_rv_cnt", rv_cnt[1], 1);
        chk("t2_m0_gnt", gnt_cnt[0], 0);

        // starvation bound with both masters busy
        clr_log();
        gnt_delay = 0; rsp_delay = 0; use_fixed = 0;
        m0_left = 2; m1_left = 8;
        repeat (40) step();
        exp_ord = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        chk("t3_ord_len", gnt_order.size(), 10);
        for (int i = 0; i < 10 && i < gnt_order.size(); i++)
            chk($sformatf("t3_ord%0d", i), gnt_order[i], exp_ord[i]);

        // response timeout, then a stray late response
        clr_log();
        m1_we = 1'b0; m1_left = 1; gnt_delay = 1; rsp_delay = 99;
        for (int i = 0; i < 40 && rv_cnt[1] == 0; i++) step();
        chk("t4_timeout_seen", rv_cnt[1], 1);
        chk("t4_err", last_err[1], 1'b1);
        chk("t4_rdata", last_rd[1], 32'h0);
        chk("t4_rsp_cycles", last_rv_cyc - last_gnt_cyc + 1, TO);
        stray_cyc = last_rv_cyc + 2;
        repeat (5) step();
        stray_cyc = -1;
        chk("t4_stray_m1", rv_cnt[1], 1);
        chk("t4_stray_m0", rv_cnt[0], 0);

        // asynchronous reset during REQ of a fetch
        clr_log();
        m0_a = 32'h40; m0_left = 1; gnt_delay = 10; rsp_delay = 0;
        for (int i = 0; i < 5 && sreq_cycles == 0; i++) step();
        step();
        #2 rst_n = 1'b0;
        m0_left = 0; m0_req_i = 1'b0; s_gnt_i = 1'b0; s_rvalid_i = 1'b0;
        mdl_reset();
        #1;
        chk("t5_s_req", s_req_o, 1'b0);
        chk("t5_s_bus", {s_we_o, s_be_o, s_addr_o, s_wdata_o}, 64'h0);
        chk("t5_gnt_rv", {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o}, 6'h0);
        chk("t5_rdata", {m0_rdata_o, m1_rdata_o}, 64'h0);
        repeat (2) step();
        #2 rst_n = 1'b1;
        clr_log();
        gnt_delay = 0;
        repeat (6) step();
        chk("t5_no_gnt", gnt_cnt[0], 0);
        chk("t5_no_rv", rv_cnt[0], 0);
        chk("t5_no_sreq", sreq_cycles, 0);

        // release reset with both requests already pending
        #2 rst_n = 1'b0;
        mdl_reset();
        clr_log();
        m0_left = 1; m1_left = 5;
        repeat (2) step();
        #2 rst_n = 1'b1;
        repeat (25) step();
        exp_ord = '{1, 1, 1, 1, 0, 1};
        chk("t6_ord_len", gnt_order.size(), 6);
        for (int i = 0; i < 6 && i < gnt_order.size(); i++)
            chk($sformatf("t6_ord%0d", i), gnt_order[i], exp_ord[i]);

        // randomized traffic
        rnd_mode = 1; gnt_delay = -1; rsp_delay = -1;
        repeat (3000) step();
        rnd_mode = 0; m0_left = 0; m1_left = 0;
        repeat (40) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port instruction/data memory of TinyRISC-V between two requesters: instruction fetch (m0, read-only) and load/store unit (m1, read/write).
- Grants one requester at a time and keeps one transaction outstanding.
- Routes the response back to the owner and raises a bus error if the memory does not respond within a timeout.
- Sits between the core pipeline front-ends and the memory port.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_LIMIT, 4, consecutive m1 grants allowed while m0 is waiting
- RSP_TIMEOUT, 16, cycles allowed in RSP before an error is forced

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- m0_req_i  input  1  fetch request; held until m0_gnt_o
- m0_addr_i  input  AW  fetch address
- m0_gnt_o  output  1  one-cycle pulse: memory accepted the fetch
- m0_rvalid_o  output  1  one-cycle pulse: fetch response valid
- m0_rdata_o  output  DW  fetch data, valid with m0_rvalid_o
- m0_err_o  output  1  bus error, qualified by m0_rvalid_o
- m1_req_i  input  1  load/store request; held until m1_gnt_o
- m1_we_i  input  1  1 = store
- m1_be_i  input  DW/8  byte enables
- m1_addr_i  input  AW  load/store address
- m1_wdata_i  input  DW  store data
- m1_gnt_o  output  1  one-cycle pulse: memory accepted the load/store
- m1_rvalid_o  output  1  load/store response or store ack
- m1_rdata_o  output  DW  load data
- m1_err_o  output  1  bus error, qualified by m1_rvalid_o
- s_req_o  output  1  memory request
- s_we_o  output  1  memory write enable
- s_be_o  output  DW/8  memory byte enables
- s_addr_o  output  AW  memory address
- s_wdata_o  output  DW  memory write data
- s_gnt_i  input  1  memory accepted the request
- s_rvalid_i  input  1  memory response; every transaction, including stores, gets exactly one
- s_rdata_i  input  DW  memory read data

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE; owner=m0; starve_cnt=0; timeout counter=0.
  - All outputs 0: s_* registers, all gnt, rvalid, rdata and err outputs.
- FSM states: IDLE, REQ, RSP.
- IDLE:
  - If any request is present, pick the owner.
  - m1 wins by default. m0 wins if only m0 requests, or if starve_cnt==STARVE_LIMIT.
  - Latch the owner's addr/we/be/wdata into the s_* registers; m0 forces we=0, be=all ones, wdata=0.
  - Set s_req_o=1 and go to REQ.
  - The first s_req_o is seen one cycle after the master's request.
- starve_cnt:
  - Increments when m1 is granted while m0_req_i=1.
  - Clears when m0 is granted or m0_req_i=0.
  - Saturates at STARVE_LIMIT.
- REQ:
  - s_req_o and all s_* outputs stay stable until s_gnt_i=1.
  - On s_gnt_i, pulse the owner's gnt_o for one cycle (registered, next cycle), drop s_req_o, clear the timeout counter, go to RSP.
  - REQ has no timeout.
- RSP:
  - Owner's rvalid_o = s_rvalid_i; owner's rdata_o = s_rdata_i (combinational pass-through); err_o=0. Go to IDLE.
  - The non-owner's rvalid_o stays 0 and its rdata_o stays 0.
  - If the counter reaches RSP_TIMEOUT-1 without s_rvalid_i: owner gets rvalid_o=1, err_o=1, rdata_o=0 for one cycle; go to IDLE.
  - A late s_rvalid_i arriving in IDLE or REQ is discarded.
- Throughput: at most one transaction per 3 cycles (IDLE→REQ→RSP). There is no arbitration in the cycle rvalid is returned.
- Simultaneous requests at reset release: m1 is granted first; with m0 held, m0 is granted after at most STARVE_LIMIT m1 transactions.
- A master dropping its req before gnt is a protocol violation. The latched request still completes and the response is routed to the owner.
- Reset mid-transaction aborts without any response. The slave must also be reset.

Decomposition:
- Shared package riscv_bus_pkg holds:
  - state enum {IDLE, REQ, RSP}
  - owner enum {OWN_IF, OWN_LSU}
  - default AW/DW localparams shared with the core
- Single flat module; no sub-module is warranted.

Test Plan:
- Reset, then m0_req_i=1, addr=0x0000_0010, s_gnt_i immediate, s_rvalid_i next cycle with rdata=0xDEAD_BEEF → s_req_o high 1 cycle after request, s_addr_o=0x10, s_we_o=0; m0_gnt_o pulses once; m0_rvalid_o=1, m0_rdata_o=0xDEAD_BEEF, m0_err_o=0; m1_rvalid_o never asserts.
- m1 store: addr=0x100, wdata=0x1234_5678, be=4'b0011, s_gnt_i delayed 3 cycles → s_* outputs stable for all 4 REQ cycles; m1_gnt_o pulses once; m1_rvalid_o on ack.
- m0 and m1 request continuously, STARVE_LIMIT=4 → grant order m1,m1,m1,m1,m0,m1,m1,m1,m1,m0; no more than 4 consecutive m1 grants.
- m1 load granted, s_rvalid_i never arrives, RSP_TIMEOUT=16 → m1_rvalid_o=1, m1_err_o=1, m1_rdata_o=0 exactly 16 cycles after entering RSP; a stray s_rvalid_i 2 cycles later is ignored.
- rst_n pulsed low during REQ of an m0 fetch → all outputs 0 immediately (asynchronous); FSM in IDLE; no m0_gnt_o or m0_rvalid_o after release until a new request.
- rst_n released while both requests are already high → m1 granted first; starve_cnt starts from 0.
